cpu_apb_bridge: RTL and testbench
=================================

Name: cpu_apb_bridge

Overview:
Downstream of the CAN register sequencer. It converts the sequencer's simple request/ack CPU bus into APB3 master transfers toward the CAN controller's register file, and returns read data, a one-cycle ack and an error flag. It runs one transfer at a time, checks address range, alignment and command legality, enforces an access timeout, and keeps a saturating error count for debug.

Parameters:
ADDR_W, 16, APB address width; cpu_addr bits above this must be zero
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort; 0 disables the timeout
ERRCNT_W, 8, width of the saturating error counter

Ports:
hclk  in  1  system clock; all logic on rising edge
rst  in  1  reset; one clock, synchronous and active-high
cpu_cs  in  1  request valid; held high until cpu_ack
cpu_read  in  1  read command
cpu_write  in  1  write command
cpu_addr  in  32  byte address
cpu_wdat  in  32  write data
cpu_rdat  out  32  read data, valid in the cpu_ack cycle of a successful read
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  error qualifier, valid only while cpu_ack=1
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
err_count  out  ERRCNT_W  saturating count of errored transfers

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. cpu_rdat=0, cpu_ack=0, cpu_err=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, err_count=0. A reset during SETUP or ACCESS aborts the APB transfer immediately and issues no ack.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: when cpu_cs=1, evaluate the request:
  - Illegal request: cpu_read==cpu_write, or cpu_addr[31:ADDR_W]!=0, or cpu_addr[1:0]!=0. Go to DONE with cpu_err=1. No APB activity.
  - Legal request: latch paddr=cpu_addr[ADDR_W-1:0], pwrite=cpu_write, and pwdata=cpu_wdat (pwdata only for writes). Set psel=1 and go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS with penable=1.
- ACCESS: psel=1, penable=1. Wait counter starts at 0 and increments each ACCESS cycle.
  - pready=1: on a read, capture prdata into cpu_rdat (cpu_rdat keeps its old value on a write). Drop psel and penable, go to DONE, cpu_err=pslverr.
  - No pready and TIMEOUT_CYCLES!=0 with counter==TIMEOUT_CYCLES-1: drop psel and penable, go to DONE, cpu_err=1, cpu_rdat unchanged.
- DONE: cpu_ack=1 (with cpu_err) for exactly one cycle. cpu_cs is ignored in this cycle, because the requester drops it on the edge after ack. Next state is IDLE, where cpu_ack=0 and cpu_err=0.
- Latency for a legal request with zero wait states: cpu_cs seen in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 (pready=1), cpu_ack at cycle 3. Each APB wait state adds one cycle.
- Illegal request: cpu_ack at cycle 1.
- The bridge does not re-sample cpu_addr, cpu_wdat or the command after IDLE. If cpu_cs drops mid-transfer, the APB transfer still completes (APB cannot abort) and cpu_ack is still pulsed.
- err_count increments by 1 on each DONE cycle with cpu_err=1 and saturates at all-ones. Only reset clears it.
- Back-to-back operation: the earliest next acceptance is the IDLE cycle immediately after DONE. There is no pipelining and no outstanding-transfer queue.

Test Plan:
- Write, cpu_addr=0x0008, cpu_wdat=0x4, pready=1 in the first ACCESS cycle -> psel high cycles 1-2, penable high cycle 2, paddr=0x0008, pwrite=1, pwdata=0x4; cpu_ack=1 with cpu_err=0 at cycle 3.
- Read, cpu_addr=0x0200, three wait states, then pready=1 with prdata=0xDEADBEEF -> penable high for 4 cycles; cpu_rdat=0xDEADBEEF with cpu_ack at cycle 6; a following write leaves cpu_rdat unchanged.
- TIMEOUT_CYCLES=16, pready held 0 -> psel and penable drop after 16 ACCESS cycles; cpu_ack with cpu_err=1; err_count=1.
- Legal read with pslverr=1 at pready -> cpu_ack with cpu_err=1. Then the illegal requests cpu_read=cpu_write=1, cpu_addr=0x0001_0008 (ADDR_W=16), and cpu_addr=0x0006 -> each gives cpu_ack at cycle 1 with cpu_err=1 and psel never asserted; err_count=4.
- Configuration sequence of 11 writes, with cpu_cs dropped for one cycle after each ack -> exactly 11 APB transfers with addresses in issue order and 11 acks; no double-issue from cpu_cs still being high during the DONE cycle.
- Assert rst during ACCESS -> psel=0 and penable=0 the next cycle, no cpu_ack, err_count=0. A new write after reset completes normally.

Source files
------------

// File: rtl/cpu_apb_bridge.sv
// cpu_apb_bridge: request/ack CPU bus to APB3 master, one transfer at a time,
// with legality checks, access timeout and a saturating error counter.
module cpu_apb_bridge #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERRCNT_W       = 8
) (
  input  logic                hclk,
  input  logic                rst,
  input  logic                cpu_cs,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [31:0]         cpu_addr,
  input  logic [31:0]         cpu_wdat,
  output logic [31:0]         cpu_rdat,
  output logic                cpu_ack,
  output logic                cpu_err,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [31:0]         pwdata,
  input  logic [31:0]         prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic [ERRCNT_W-1:0] err_count
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_rdat;
  logic                r_ack, r_err, r_psel, r_penable, r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [31:0]         r_pwdata;
  logic [ERRCNT_W-1:0] r_errcnt;
  logic                w_illegal;
  logic                w_timeout;
  assign w_illegal = (cpu_read == cpu_write) || (|cpu_addr[31:ADDR_W]) || (|cpu_addr[1:0]);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);
  always_ff @(posedge hclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_errcnt  <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (r_state == DONE && r_err && !(&r_errcnt)) r_errcnt <= r_errcnt + 1'b1;
      case (r_state)
        IDLE: if (cpu_cs) begin
          if (w_illegal) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_paddr  <= cpu_addr[ADDR_W-1:0];
            r_pwrite <= cpu_write;
            if (cpu_write) r_pwdata <= cpu_wdat;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: if (pready || w_timeout) begin
          if (pready && !r_pwrite) r_rdat <= prdata;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_ack     <= 1'b1;
          r_err     <= pready ? pslverr : 1'b1;
          r_state   <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign cpu_rdat  = r_rdat;
  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign err_count = r_errcnt;
endmodule

// File: tb/tb_cpu_apb_bridge.sv
// tb_cpu_apb_bridge: directed scenario tests for cpu_apb_bridge (ADDR_W=16, TIMEOUT_CYCLES=16).
module tb_cpu_apb_bridge;
  logic        hclk = 1'b0, rst = 1'b0;
  logic        cpu_cs = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdat = '0, cpu_rdat;
  logic        cpu_ack, cpu_err;
  logic [15:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [7:0]  err_count;

  int checks = 0, failures = 0;
  int x_cyc, x_pen, x_psel_rises, x_setup_cyc, x_acks;
  logic x_err, x_done;
  logic [31:0] x_rdat, x_pwdata;
  logic [15:0] x_paddr;
  logic x_pwrite;
  logic [15:0] q_addr[$];

  cpu_apb_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(16), .ERRCNT_W(8)) dut (
    .hclk(hclk), .rst(rst), .cpu_cs(cpu_cs), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr), .err_count(err_count)
  );

  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  // Runs one request to its ack; waits<0 means pready never rises. cpu_cs stays high
  // through the ack cycle and drops for one IDLE cycle afterwards.
  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input int waits, input logic slv,
                         input logic [31:0] pd);
    logic prev_psel;
    int k;
    cpu_cs = 1'b1; cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdat = wdat;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    x_cyc = 0; x_pen = 0; x_psel_rises = 0; x_setup_cyc = -1; x_done = 1'b0; k = 0;
    prev_psel = psel;
    for (int c = 1; c <= 60 && !x_done; c++) begin
      tick();
      if (psel && !prev_psel) begin
        x_psel_rises++;
        x_setup_cyc = c;
        x_paddr = paddr; x_pwrite = pwrite; x_pwdata = pwdata;
        q_addr.push_back(paddr);
      end
      prev_psel = psel;
      pready = 1'b0; pslverr = 1'b0;
      if (psel && penable) begin
        x_pen++;
        pready = (waits >= 0) && (k == waits);
        pslverr = pready && slv;
        prdata = pready ? pd : 32'h0;
        k++;
      end
      if (cpu_ack) begin
        x_done = 1'b1; x_cyc = c; x_err = cpu_err; x_rdat = cpu_rdat; x_acks++;
      end
    end
    checks++;
    if (!x_done) begin
      failures++;
      $display("FAIL ack_timeout addr=%h: no cpu_ack within 60 cycles", addr);
    end
    pready = 1'b0;
    tick();
    cpu_cs = 1'b0;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_err !== 1'b0) begin
      failures++;
      $display("FAIL ack_one_cycle: ack=%b err=%b expected 0 0", cpu_ack, cpu_err);
    end
    tick();
    if (psel) x_psel_rises++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({cpu_ack, cpu_err, psel, penable, pwrite} !== 5'b0 || cpu_rdat !== 32'h0 ||
        paddr !== 16'h0 || pwdata !== 32'h0 || err_count !== 8'h0) begin
      failures++;
      $display("FAIL reset: ack=%b err=%b psel=%b pen=%b pwr=%b rdat=%h paddr=%h pwdata=%h ec=%0d expected all 0",
               cpu_ack, cpu_err, psel, penable, pwrite, cpu_rdat, paddr, pwdata, err_count);
    end
  endtask

  task automatic test_write;
    do_xfer(1'b0, 1'b1, 32'h0008, 32'h4, 0, 1'b0, 32'h0);
    checks++;
    if (x_setup_cyc !== 1 || x_pen !== 1 || x_cyc !== 3) begin
      failures++;
      $display("FAIL write_timing: setup=%0d pen=%0d ack=%0d expected 1 1 3", x_setup_cyc, x_pen, x_cyc);
    end
    checks++;
    if (x_paddr !== 16'h0008 || x_pwrite !== 1'b1 || x_pwdata !== 32'h4) begin
      failures++;
      $display("FAIL write_apb: paddr=%h pwrite=%b pwdata=%h expected 0008 1 00000004", x_paddr, x_pwrite, x_pwdata);
    end
    checks++;
    if (x_err !== 1'b0) begin
      failures++;
      $display("FAIL write_err: got %b expected 0", x_err);
    end
  endtask

  task automatic test_read_wait;
    do_xfer(1'b1, 1'b0, 32'h0200, 32'h0, 3, 1'b0, 32'hDEADBEEF);
    checks++;
    if (x_pen !== 4 || x_cyc !== 6 || x_paddr !== 16'h0200 || x_pwrite !== 1'b0) begin
      failures++;
      $display("FAIL read_wait: pen=%0d ack=%0d paddr=%h pwrite=%b expected 4 6 0200 0", x_pen, x_cyc, x_paddr, x_pwrite);
    end
    checks++;
    if (x_rdat !== 32'hDEADBEEF || x_err !== 1'b0) begin
      failures++;
      $display("FAIL read_data: rdat=%h err=%b expected deadbeef 0", x_rdat, x_err);
    end
    do_xfer(1'b0, 1'b1, 32'h0004, 32'h55, 0, 1'b0, 32'h12345678);
    checks++;
    if (x_rdat !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_keeps_rdat: rdat=%h expected deadbeef", x_rdat);
    end
  endtask

  task automatic test_timeout;
    do_xfer(1'b1, 1'b0, 32'h0010, 32'h0, -1, 1'b0, 32'h0);
    checks++;
    if (x_pen !== 16 || x_cyc !== 18 || x_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout: pen=%0d ack=%0d err=%b expected 16 18 1", x_pen, x_cyc, x_err);
    end
    checks++;
    if (x_rdat !== 32'hDEADBEEF || err_count !== 8'd1) begin
      failures++;
      $display("FAIL timeout_state: rdat=%h ec=%0d expected deadbeef 1", x_rdat, err_count);
    end
  endtask

  task automatic test_errors;
    logic [31:0] a[3];
    logic rd[3], wr[3];
    rst = 1'b1; tick(); rst = 1'b0;
    do_xfer(1'b1, 1'b0, 32'h0020, 32'h0, 1, 1'b1, 32'hCAFE0000);
    checks++;
    if (x_err !== 1'b1 || x_cyc !== 4) begin
      failures++;
      $display("FAIL slverr: err=%b ack=%0d expected 1 4", x_err, x_cyc);
    end
    a[0] = 32'h0000_0010; rd[0] = 1'b1; wr[0] = 1'b1;
    a[1] = 32'h0001_0008; rd[1] = 1'b1; wr[1] = 1'b0;
    a[2] = 32'h0000_0006; rd[2] = 1'b0; wr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_xfer(rd[i], wr[i], a[i], 32'h1, 0, 1'b0, 32'h0);
      checks++;
      if (x_cyc !== 1 || x_err !== 1'b1 || x_psel_rises !== 0) begin
        failures++;
        $display("FAIL illegal_%0d: ack=%0d err=%b psel_rises=%0d expected 1 1 0", i, x_cyc, x_err, x_psel_rises);
      end
    end
    checks++;
    if (err_count !== 8'd4) begin
      failures++;
      $display("FAIL err_count: got %0d expected 4", err_count);
    end
  endtask

  task automatic test_back_to_back;
    int rises;
    q_addr.delete();
    x_acks = 0; rises = 0;
    for (int i = 0; i < 11; i++) begin
      do_xfer(1'b0, 1'b1, 32'h0100 + 32'(i * 4), 32'(i), 0, 1'b0, 32'h0);
      rises += x_psel_rises;
    end
    checks++;
    if (x_acks !== 11 || rises !== 11 || q_addr.size() !== 11) begin
      failures++;
      $display("FAIL b2b_count: acks=%0d psel_rises=%0d issued=%0d expected 11 11 11", x_acks, rises, q_addr.size());
    end
    for (int i = 0; i < 11 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== 16'h0100 + 16'(i * 4)) begin
        failures++;
        $display("FAIL b2b_addr_%0d: got %h expected %h", i, q_addr[i], 16'h0100 + 16'(i * 4));
      end
    end
  endtask

  task automatic test_reset_mid;
    cpu_cs = 1'b1; cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'h0040; cpu_wdat = 32'h9;
    pready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      failures++;
      $display("FAIL mid_access: psel=%b pen=%b expected 1 1", psel, penable);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_cs = 1'b0;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || cpu_ack !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: psel=%b pen=%b ack=%b ec=%0d expected 0 0 0 0", psel, penable, cpu_ack, err_count);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || psel !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: ack=%b psel=%b expected 0 0", cpu_ack, psel);
    end
    do_xfer(1'b0, 1'b1, 32'h0044, 32'hA5, 0, 1'b0, 32'h0);
    checks++;
    if (x_cyc !== 3 || x_err !== 1'b0 || x_paddr !== 16'h0044 || x_pwdata !== 32'hA5) begin
      failures++;
      $display("FAIL post_reset_write: ack=%0d err=%b paddr=%h pwdata=%h expected 3 0 0044 000000a5",
               x_cyc, x_err, x_paddr, x_pwdata);
    end
  endtask

  initial begin
    x_acks = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
